// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, NOP word, reset PC,
// immediate-select encoding and the immediate extraction helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_t;

    // Operand is inst[31:7]; bit numbering kept so slices read
    // like the ISA manual.
    function automatic logic [31:0] imm_gen(
        input imm_sel_t    sel,
        input logic [31:7] i
    );
        logic [31:0] imm;
        imm = 32'h0;
        unique case (sel)
            IMM_I: imm = {{20{i[31]}}, i[31:20]};
            IMM_S: imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B: imm = {{19{i[31]}}, i[31], i[7],
                          i[30:25], i[11:8], 1'b0};
            IMM_U: imm = {i[31:12], 12'h000};
            IMM_J: imm = {{11{i[31]}}, i[31], i[19:12],
                          i[20], i[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: redirect load has priority over increment.
// Ports: clk, rst_n, load/load_pc (aligned target), inc, pc.
module pc_reg import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        inc,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + 32'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one-outstanding-request FSM plus decode buffer.
// Ports: clk, rst_n, imem_req/addr/rvalid/rdata, redirect_valid/pc,
// if_valid/inst/pc to decode, id_ready from decode.
module fetch_unit import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic         consume;
    logic         buf_free;
    logic         take;

    assign target   = redirect_pc & 32'hFFFF_FFFC;
    assign consume  = if_valid && id_ready;
    assign buf_free = !if_valid || consume;
    // Accepted response: only in WAIT and not killed by a redirect.
    assign take     = (state == WAIT) && imem_rvalid && !redirect_valid;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect_valid),
        .load_pc (target),
        .inc     (take),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            if_valid  <= 1'b0;
            if_inst   <= NOP_INST;
            if_pc     <= RESET_PC;
        end else begin
            imem_req <= 1'b0;
            if (redirect_valid || consume) begin
                if_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (!redirect_valid && buf_free) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        state <= imem_rvalid ? IDLE : DROP;
                    end else if (imem_rvalid) begin
                        if_inst  <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory.
// Ports: none (top-level bench).
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int cnt = 0;
    int req_cnt = 0;
    int rc;
    logic [31:0] pend;
    bit stale_seen = 1'b0;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00C4_8413;
            32'h0000_0004: return 32'hFFC4_8413;
            32'h0000_0008: return 32'h0094_1823;
            32'h0000_0100: return 32'hFE94_1E23;
            default:       return a + 32'h1000_0013;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!if_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] a);
        int n = 0;
        while (!imem_req && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, a);
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    // Memory model: captures a request, answers lat cycles later.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(pend);
                    end
                end
                if (imem_req) begin
                    pend = imem_addr;
                    cnt  = lat;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (imem_req) req_cnt++;
            if (if_valid && if_inst == 32'h0094_1823) stale_seen = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_inst", if_inst, 32'h0000_0013);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        rst_n = 1'b1;

        // Sequential fetch, 1-cycle memory.
        wait_req("first", 32'h0);
        wait_valid("seq0");
        chk("seq0_inst", if_inst, 32'h00C4_8413);
        chk("seq0_pc", if_pc, 32'h0);
        chk("imm12", imm_gen(IMM_I, if_inst[31:7]), 32'd12);
        @(negedge clk);
        chk("seq_clear", 32'(if_valid), 32'd0);
        wait_valid("seq1");
        chk("seq1_inst", if_inst, 32'hFFC4_8413);
        chk("seq1_pc", if_pc, 32'h4);
        chk("imm_m4", imm_gen(IMM_I, if_inst[31:7]), 32'hFFFF_FFFC);

        // Stall: 3-cycle memory, decode not ready.
        @(negedge clk);
        rst_n    = 1'b0;
        id_ready = 1'b0;
        lat      = 3;
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("stall");
        rc = req_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_inst", if_inst, 32'h00C4_8413);
            chk("hold_pc", if_pc, 32'h0);
        end
        chk("hold_noreq", 32'(req_cnt), 32'(rc));
        id_ready = 1'b1;
        wait_req("after_stall", 32'h4);
        wait_valid("after_stall");
        chk("after_stall_inst", if_inst, 32'hFFC4_8413);

        // Redirect while waiting; stale word must be dropped.
        wait_req("stale", 32'h8);
        @(negedge clk);
        redirect(32'h0000_0100);
        wait_req("redir", 32'h100);
        wait_valid("redir");
        chk("redir_inst", if_inst, 32'hFE94_1E23);
        chk("redir_pc", if_pc, 32'h100);
        chk("no_stale", 32'(stale_seen), 32'd0);

        // Misaligned redirect target, issued in IDLE.
        redirect(32'h0000_0203);
        chk("redir_noreq", 32'(imem_req), 32'd0);
        wait_req("align", 32'h200);
        wait_valid("align");
        chk("align_pc", if_pc, 32'h200);
        chk("align_inst", if_inst, 32'h1000_0213);

        // Redirect coincident with the response.
        lat = 1;
        wait_req("coinc_pre", 32'h204);
        @(negedge clk);
        redirect(32'h0000_0300);
        chk("coinc_valid", 32'(if_valid), 32'd0);
        wait_req("coinc", 32'h300);
        wait_valid("coinc");
        chk("coinc_pc", if_pc, 32'h300);
        chk("coinc_inst", if_inst, 32'h1000_0313);

        // Asynchronous reset in the middle of WAIT.
        lat = 3;
        wait_req("mid", 32'h304);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_inst", if_inst, 32'h0000_0013);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_req("post_rst", 32'h0);

        // PC wrap-around at the top of the address space.
        wait_valid("wrap0");
        chk("wrap0_pc", if_pc, 32'h0);
        redirect(32'hFFFF_FFFC);
        wait_req("top", 32'hFFFF_FFFC);
        wait_valid("top");
        chk("top_pc", if_pc, 32'hFFFF_FFFC);
        chk("top_inst", if_inst, 32'h1000_000F);
        wait_req("wrap", 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
